// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: one hold byte + shifter, 8N1 (8E1 with UART_TX_PARITY_EN); tx falls 1 cycle after hold fills.
// Status on out = {overflow, busy, hold_full}; a data write while hold is full is dropped and sets the sticky overflow flag.
module uart_tx_port #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    output logic [15:0] out,
    output logic        tx
);

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        ovf_q, ovf_d;
    logic        tx_q, tx_d;
    logic        baud_end;
    logic        transfer;

    assign baud_end = (baud_q == BAUD_MAX);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovf_d       = ovf_q;
        transfer    = 1'b0;
        tx_d        = 1'b1;

        if (state_q != S_IDLE) begin
            baud_d = baud_end ? 16'd0 : baud_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    transfer = 1'b1;
                    state_d  = S_START;
                    baud_d   = 16'd0;
                end
            end
            S_START: begin
                if (baud_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (baud_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    // Chain straight into the next start bit when a byte is waiting.
                    if (hold_full_q) begin
                        transfer = 1'b1;
                        state_d  = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = 16'd0;
            end
        endcase

        if (transfer) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
        end

        // A transfer in this cycle frees the hold register for the incoming byte.
        if (load) begin
            if (in[15]) begin
                ovf_d = 1'b0;
            end else if (!hold_full_q || transfer) begin
                hold_d      = in[7:0];
                hold_full_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = ^shift_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            baud_q      <= 16'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            ovf_q       <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ovf_q       <= ovf_d;
            tx_q        <= tx_d;
        end
    end

    assign tx  = tx_q;
    assign out = {13'd0, ovf_q, (state_q != S_IDLE), hold_full_q};

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port at CLKS_PER_BIT = 4; parity frames covered when UART_TX_PARITY_EN is defined.
module tb_uart_tx_port;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        load;
    logic [15:0] dout;
    logic        tx;

    int n_cmp;
    int n_bad;

    uart_tx_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (din),
        .load (load),
        .out  (dout),
        .tx   (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one write for exactly one rising edge; returns at the following falling edge.
    task automatic wr(input logic [15:0] w);
        din  = w;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        din  = 16'h0000;
    endtask

    // Checks tx and busy for each cycle of a frame; current negedge is frame sample 'skip'.
    task automatic check_frame(input string tag, input logic [7:0] b, input int skip);
        logic exp_bit;
        for (int i = skip; i < NBITS * CPB; i++) begin
            int k;
            if (i > skip) @(negedge clk);
            k = i / CPB;
            if (k == 0)            exp_bit = 1'b0;
            else if (k <= 8)       exp_bit = b[k-1];
            else if (k == NBITS-1) exp_bit = 1'b1;
            else                   exp_bit = ^b;
            check_eq($sformatf("%s_tx_bit%0d_c%0d", tag, k, i % CPB), {15'd0, tx}, {15'd0, exp_bit});
            check_eq($sformatf("%s_busy_c%0d", tag, i), {15'd0, dout[1]}, 16'h0001);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        din   = 16'h0000;
        load  = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_tx", {15'd0, tx}, 16'h0001);
        check_eq("rst_out", dout, 16'h0000);
        rst_n = 1'b1;

        // Idle with no writes
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_eq("idle_tx", {15'd0, tx}, 16'h0001);
            check_eq("idle_out", dout, 16'h0000);
        end

        // Single frame 0x55
        wr(16'h0055);
        check_eq("w55_hold_out", dout, 16'h0001);
        check_eq("w55_pre_tx", {15'd0, tx}, 16'h0001);
        @(negedge clk);
        check_frame("f55", 8'h55, 0);
        @(negedge clk);
        check_eq("f55_end_out", dout, 16'h0000);
        check_eq("f55_end_tx", {15'd0, tx}, 16'h0001);
        repeat (3) @(negedge clk);

        // Back-to-back A,B
        wr(16'h0041);
        wr(16'h0042);
        check_eq("ab_out_start", dout, 16'h0003);
        check_frame("fA", 8'h41, 0);
        @(negedge clk);
        check_eq("ab_chain_out", dout, 16'h0002);
        check_frame("fB", 8'h42, 0);
        @(negedge clk);
        check_eq("ab_end_out", dout, 16'h0000);
        repeat (3) @(negedge clk);

        // Overflow: third write dropped
        wr(16'h0041);
        wr(16'h0042);
        wr(16'h0043);
        check_eq("ovf_out", dout, 16'h0007);
        check_frame("oA", 8'h41, 1);
        @(negedge clk);
        check_frame("oB", 8'h42, 0);
        @(negedge clk);
        check_eq("ovf_end_out", dout, 16'h0004);
        check_eq("ovf_end_tx", {15'd0, tx}, 16'h0001);
        wr(16'h8000);
        check_eq("ctl_clr_out", dout, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("ctl_no_tx", {15'd0, tx}, 16'h0001);
            check_eq("ctl_no_busy", dout, 16'h0000);
        end

        // Reset during DATA bit 3 of 0xFF
        wr(16'h00FF);
        @(negedge clk);
        check_eq("ff_start_tx", {15'd0, tx}, 16'h0000);
        repeat (17) @(negedge clk);
        check_eq("ff_bit3_busy", dout, 16'h0002);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_tx", {15'd0, tx}, 16'h0001);
        check_eq("midrst_out", dout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("postrst_tx", {15'd0, tx}, 16'h0001);
        wr(16'h0001);
        @(negedge clk);
        check_frame("f01", 8'h01, 0);
        @(negedge clk);
        check_eq("f01_end_out", dout, 16'h0000);

`ifdef UART_TX_PARITY_EN
        repeat (2) @(negedge clk);
        wr(16'h0007);
        @(negedge clk);
        check_frame("p07", 8'h07, 0);
        @(negedge clk);
        check_eq("p07_end_out", dout, 16'h0000);
        wr(16'h0003);
        @(negedge clk);
        check_frame("p03", 8'h03, 0);
        @(negedge clk);
        check_eq("p03_end_out", dout, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped UART transmitter sitting directly downstream of the Memory block's I/O decode.
- The Memory block asserts load with the 16-bit CPU data word when the UART data address is hit; this block serialises the low byte onto a TX pin.
- Status is returned on out for the Memory output mux, so Hack programs poll before writing.
- Holds one buffered byte so the CPU can queue the next byte while the current one shifts.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200); legal range 2..65535.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  16  write data from CPU via Memory; bits [7:0] = byte; bit 15 = control-write flag.
- load  input  1  write strobe, already address-decoded by Memory; sampled on rising clk.
- out  output  16  status word, combinational from registers: bit0 = hold_full, bit1 = busy, bit2 = overflow, bits [15:3] = 0.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (rst_n = 0, asynchronous): tx = 1, state IDLE, hold_full = 0, overflow = 0, bit/baud counters = 0, out = 16'h0000. Reset mid-frame aborts the frame immediately; tx returns high with no glitch low.
- Write decode on rising clk with load = 1:
  - in[15] = 1 (control write): clear overflow; the byte is not queued.
  - in[15] = 0 (data write): accepted if hold_full = 0, or if the FSM transfers hold to the shifter in the same cycle. On accept, hold <= in[7:0] and hold_full <= 1.
  - Data write with hold_full = 1 and no same-cycle transfer: write dropped, overflow <= 1 (sticky), hold unchanged.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: tx = 1. If hold_full = 1: shifter <= hold, hold_full <= 0, go START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. After bit 7: go PARITY if enabled, else STOP.
  - PARITY: see Optional Feature.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. Then, if hold_full = 1, load the shifter and go START directly (back-to-back frames, no idle gap); else go IDLE.
- busy = (state != IDLE).
- Latency:
  - Data write at edge k sets hold_full after edge k.
  - Transfer happens at edge k+1; tx falls after edge k+1.
  - Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Bit counter is 3 bits and wraps from 7 to 0 on the DATA exit.
- All outputs are registered except out; tx comes from a flop.
- Simultaneous events:
  - Data write plus control write are impossible (single word).
  - Data write in the IDLE transfer cycle is accepted into the freed hold.
  - Write during the STOP-to-START chain transfer is likewise accepted.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state follows DATA; tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame = 11 bit-times.
- Undefined: PARITY state and parity logic are absent; DATA goes straight to STOP; frame = 10 bit-times.

Test Plan (CLKS_PER_BIT = 4, parity off unless noted):
- Reset, no writes for 50 cycles -> tx = 1 throughout, out = 16'h0000.
- Data write 16'h0055 -> tx, 4 cycles per bit: 0,1,0,1,0,1,0,1,0,1. Start falls 1 cycle after the write edge; out = 16'h0002 during the frame and 16'h0000 after 40 cycles.
- Write 16'h0041 then 16'h0042 on consecutive cycles -> second write accepted (hold freed by the transfer). Two frames back-to-back with no idle gap between stop and start; overflow stays 0.
- Write 16'h0041, 16'h0042, 16'h0043 on consecutive cycles -> 16'h0043 dropped, out bit2 = 1. Only 'A','B' are transmitted. A later write 16'h8000 clears bit2 and transmits nothing.
- Assert rst_n = 0 during DATA bit 3 of 16'h00FF -> tx = 1 immediately, out = 0. After release, the next write 16'h0001 transmits cleanly.
- With UART_TX_PARITY_EN defined, write 16'h0007 -> parity bit = 1, frame 44 cycles. Write 16'h0003 -> parity bit = 0.
